// File: rtl/uart_rx_frontend_pkg.sv
// rtl/uart_rx_frontend_pkg.sv - shared constants and types for the UART receive front end
// Purpose: default build-time sizes for the receive front end and the autobaud FSM state type.
// Ports: none.
package uart_rx_frontend_pkg;

    localparam int UART_DIV_WIDTH        = 16;
    localparam int UART_RXFE_SYNC_STAGES = 2;
    localparam int UART_RXFE_FILT_LEN    = 3;
    localparam int UART_RXFE_BRK_BITS    = 11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FALL = 2'd1,
        MEASURE   = 2'd2
    } uart_abr_state_e;

endpackage

// File: rtl/uart_rx_frontend_if.sv
// rtl/uart_rx_frontend_if.sv - signal bundle between the UART wrapper and the receive front end
// Purpose: groups the pad, configuration, filtered line, break and autobaud signals.
// Ports: master drives rx_i, cfg_div_i, abr_arm_i; slave (the front end) drives everything else.
interface uart_rx_frontend_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 rx_i;
    logic [DIV_WIDTH-1:0] cfg_div_i;
    logic                 rx_o;
    logic                 brk_o;
    logic                 brk_stb_o;
    logic                 abr_arm_i;
    logic                 abr_busy_o;
    logic                 abr_valid_o;
    logic                 abr_err_o;
    logic [DIV_WIDTH-1:0] abr_div_o;

    modport master (
        output rx_i, cfg_div_i, abr_arm_i,
        input  rx_o, brk_o, brk_stb_o, abr_busy_o, abr_valid_o, abr_err_o, abr_div_o
    );

    modport slave (
        input  rx_i, cfg_div_i, abr_arm_i,
        output rx_o, brk_o, brk_stb_o, abr_busy_o, abr_valid_o, abr_err_o, abr_div_o
    );
endinterface

// File: rtl/uart_rx_filter.sv
// rtl/uart_rx_filter.sv - pad synchronizer plus debounce filter for the UART receive line
// Purpose: brings the asynchronous pad into clk_i and removes pulses shorter than FILT_LEN cycles.
// Ports: clk_i, rst_i (sync, active-high), rx_i (raw pad), rx_o (filtered, registered, resets to 1).
module uart_rx_filter
    import uart_rx_frontend_pkg::*;
#(
    parameter int SYNC_STAGES = UART_RXFE_SYNC_STAGES,
    parameter int FILT_LEN    = UART_RXFE_FILT_LEN
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FILT_LEN-1:0]    filt_q;
    logic [FILT_LEN-1:0]    filt_next;

    generate
        if (FILT_LEN == 1) begin : g_filt_single
            assign filt_next = sync_q[SYNC_STAGES-1];
        end else begin : g_filt_shift
            assign filt_next = {filt_q[FILT_LEN-2:0], sync_q[SYNC_STAGES-1]};
        end
    endgenerate

    // Everything resets to the idle (high) line level so no false start is seen.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
            filt_q <= '1;
            rx_o   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            filt_q <= filt_next;
            // Change only on unanimous history; mixed history holds the last level.
            if (&filt_q) begin
                rx_o <= 1'b1;
            end else if (~|filt_q) begin
                rx_o <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/uart_rx_frontend.sv
// rtl/uart_rx_frontend.sv - UART receive conditioning: filter, break detect, optional autobaud
// Purpose: feeds uart_rx a clean line, flags line breaks and measures the start-bit width.
// Ports: clk_i, rst_i (sync, active-high), bus (uart_rx_frontend_if.slave).
// Build option: UART_RXFE_AUTOBAUD_EN builds the autobaud FSM; otherwise abr_* outputs are 0.
module uart_rx_frontend
    import uart_rx_frontend_pkg::*;
#(
    parameter int SYNC_STAGES = UART_RXFE_SYNC_STAGES,
    parameter int FILT_LEN    = UART_RXFE_FILT_LEN,
    parameter int BRK_BITS    = UART_RXFE_BRK_BITS,
    parameter int DIV_WIDTH   = UART_DIV_WIDTH
) (
    input logic              clk_i,
    input logic              rst_i,
    uart_rx_frontend_if.slave bus
);
    localparam int BRK_W = $clog2(BRK_BITS + 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    logic rx_filt;

    uart_rx_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_filter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rx_i  (bus.rx_i),
        .rx_o  (rx_filt)
    );

    assign bus.rx_o = rx_filt;

    // Break detection: prescaled count of low bit periods.
    logic [DIV_WIDTH-1:0] div_eff;
    logic [DIV_WIDTH-1:0] pre_q;
    logic [BRK_W-1:0]     bits_q;
    logic                 brk_q;
    logic                 brk_stb_q;

    assign div_eff = (bus.cfg_div_i == '0) ? DIV_ONE : bus.cfg_div_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q     <= '0;
            bits_q    <= '0;
            brk_q     <= 1'b0;
            brk_stb_q <= 1'b0;
        end else begin
            brk_stb_q <= 1'b0;
            if (rx_filt) begin
                pre_q  <= '0;
                bits_q <= '0;
                brk_q  <= 1'b0;
            end else if (pre_q >= div_eff - DIV_ONE) begin
                // '>=' lets a divisor lowered mid-count wrap at once instead of running to 2^N.
                pre_q <= '0;
                if (bits_q != BRK_W'(BRK_BITS)) begin
                    bits_q <= bits_q + BRK_W'(1);
                    if (bits_q == BRK_W'(BRK_BITS - 1)) begin
                        brk_q     <= 1'b1;
                        brk_stb_q <= 1'b1;
                    end
                end
            end else begin
                pre_q <= pre_q + DIV_ONE;
            end
        end
    end

    assign bus.brk_o     = brk_q;
    assign bus.brk_stb_o = brk_stb_q;

`ifdef UART_RXFE_AUTOBAUD_EN
    uart_abr_state_e      state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 busy_q;
    logic                 rx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= (state_d != IDLE);
            rx_q    <= rx_filt;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.abr_arm_i) begin
                    state_d = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                // The falling-edge cycle itself is the first low cycle, hence start at 1.
                if (rx_q && !rx_filt) begin
                    state_d = MEASURE;
                    cnt_d   = DIV_ONE;
                end
            end
            MEASURE: begin
                if (rx_filt) begin
                    div_d   = cnt_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (&cnt_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.abr_busy_o  = busy_q;
    assign bus.abr_valid_o = valid_q;
    assign bus.abr_err_o   = err_q;
    assign bus.abr_div_o   = div_q;
`else
    logic unused_abr_arm;
    assign unused_abr_arm  = bus.abr_arm_i;
    assign bus.abr_busy_o  = 1'b0;
    assign bus.abr_valid_o = 1'b0;
    assign bus.abr_err_o   = 1'b0;
    assign bus.abr_div_o   = '0;
`endif
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb/tb_uart_rx_frontend.sv - directed self-checking bench for uart_rx_frontend
module tb_uart_rx_frontend;
    localparam int DW      = 8;
    localparam int BRK     = 11;
    localparam int LAT     = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int exp_brk_q[$];
    int exp_div_q[$];
    int exp_err_q[$];
    int kept_div = 0;

    uart_rx_frontend_if #(.DIV_WIDTH(DW)) bus ();

    uart_rx_frontend #(.DIV_WIDTH(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Output monitor: every pulse pops the expectation queued when its stimulus was driven.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.brk_stb_o) begin
                if (exp_brk_q.size() == 0) chk("brk_stb_unexpected", 1, 0);
                else chk("brk_stb_cycle", cyc, exp_brk_q.pop_front());
            end
            if (bus.abr_valid_o) begin
                if (exp_div_q.size() == 0) chk("abr_valid_unexpected", 1, 0);
                else chk("abr_div", {24'd0, bus.abr_div_o}, exp_div_q.pop_front());
            end
            if (bus.abr_err_o) begin
                if (exp_err_q.size() == 0) chk("abr_err_unexpected", 1, 0);
                else begin
                    chk("abr_err_cycle", cyc, exp_err_q.pop_front());
                    chk("abr_div_kept", {24'd0, bus.abr_div_o}, kept_div);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Low pulse of n cycles on rx_i; brk_o is expected high for d in [brk_from, brk_to].
    task automatic pulse_run(input string tag, input int n, input int exp_low,
                             input int brk_from, input int brk_to);
        int c0, low, first, mm, d;
        logic exp_brk;
        c0 = cyc; low = 0; first = -1; mm = 0;
        if (brk_from >= 0) exp_brk_q.push_back(c0 + brk_from);
        bus.rx_i = 1'b0;
        for (int i = 0; i < n + 20; i++) begin
            @(negedge clk);
            if (i == n - 1) bus.rx_i = 1'b1;
            d = cyc - c0;
            if (!bus.rx_o) begin
                low++;
                if (first < 0) first = d;
            end
            exp_brk = (brk_from >= 0) && (d >= brk_from) && (d <= brk_to);
            if (bus.brk_o !== exp_brk) mm++;
        end
        chk({tag, "_low_cycles"}, low, exp_low);
        if (exp_low > 0) chk({tag, "_fall_latency"}, first, LAT);
        chk({tag, "_brk_level_bad_cycles"}, mm, 0);
    endtask

    task automatic send_55(input int bit_cycles);
        logic [7:0] b;
        b = 8'h55;
        bus.rx_i = 1'b0;
        step(40);
        bus.abr_arm_i = 1'b1;   // arm while busy: must be ignored
        step(1);
        bus.abr_arm_i = 1'b0;
        step(bit_cycles - 41);
        for (int i = 0; i < 8; i++) begin
            bus.rx_i = b[i];
            step(bit_cycles);
        end
        bus.rx_i = 1'b1;
        step(bit_cycles);
    endtask

    initial begin
        bus.rx_i      = 1'b0;
        bus.cfg_div_i = 8'd4;
        bus.abr_arm_i = 1'b0;
        step(3);
        chk("reset_rx_o", bus.rx_o, 1);
        chk("reset_brk", bus.brk_o, 0);
        chk("reset_brk_stb", bus.brk_stb_o, 0);
        chk("reset_busy", bus.abr_busy_o, 0);
        chk("reset_valid", bus.abr_valid_o, 0);
        chk("reset_err", bus.abr_err_o, 0);
        chk("reset_div", {24'd0, bus.abr_div_o}, 0);

        rst = 1'b0;
        step(5);
        chk("rx_o_high_after_5_edges", bus.rx_o, 1);
        step(1);
        chk("rx_o_low_after_6_edges", bus.rx_o, 0);
        bus.rx_i = 1'b1;
        step(20);

        pulse_run("glitch2", 2, 0, -1, 0);
        pulse_run("pulse3", 3, 3, -1, 0);
        pulse_run("brk100", 100, 100, LAT + BRK * 4, LAT + 100);
        pulse_run("nobrk43", 43, 43, -1, 0);
        bus.cfg_div_i = 8'd0;
        pulse_run("brk_div0", 20, 20, LAT + BRK, LAT + 20);

        bus.cfg_div_i = 8'd87;
        bus.abr_arm_i = 1'b1;
        step(1);
        bus.abr_arm_i = 1'b0;
`ifdef UART_RXFE_AUTOBAUD_EN
        chk("abr_busy_after_arm", bus.abr_busy_o, 1);
        exp_div_q.push_back(87);
`else
        chk("abr_busy_after_arm", bus.abr_busy_o, 0);
`endif
        send_55(87);
        step(10);
        chk("abr_busy_after_frame", bus.abr_busy_o, 0);
        chk("abr_div_after_frame", {24'd0, bus.abr_div_o},
`ifdef UART_RXFE_AUTOBAUD_EN
            87);
`else
            0);
`endif

`ifdef UART_RXFE_AUTOBAUD_EN
        kept_div = 87;
`endif
        bus.abr_arm_i = 1'b1;
        step(1);
        bus.abr_arm_i = 1'b0;
`ifdef UART_RXFE_AUTOBAUD_EN
        exp_err_q.push_back(cyc + LAT + 256);
`endif
        pulse_run("ovf300", 300, 300, -1, 0);
        chk("abr_busy_after_ovf", bus.abr_busy_o, 0);
        chk("abr_div_after_ovf", {24'd0, bus.abr_div_o}, kept_div);

        step(5);
        chk("brk_queue_drained", exp_brk_q.size(), 0);
        chk("div_queue_drained", exp_div_q.size(), 0);
        chk("err_queue_drained", exp_err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
